// File: rtl/mem_lvt_2wnr.sv
// mem_lvt_2wnr: two-write / N-read memory built from a live value table.
// Each write port owns a bank. Each bank is replicated once per read port.
// A 1-bit-per-word live value table records which bank holds the newest copy.
// Reads are registered with one cycle of latency. Out-of-range addresses
// read as zero and are never written.
// When both ports write the same address in one cycle, port 1 wins and the
// sticky write_conflict flag is set.
// Optional feature: define MEM_LVT_BYPASS_EN for write-first reads. A read of
// an address written in the same cycle then returns the new data. Without the
// macro, reads are read-first and return the pre-write contents.

module mem_lvt_2wnr #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int READ_PORTS = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         we_0,
    input  logic [ADDR_W-1:0]            write_addr_0,
    input  logic [WIDTH-1:0]             write_data_0,
    input  logic                         we_1,
    input  logic [ADDR_W-1:0]            write_addr_1,
    input  logic [WIDTH-1:0]             write_data_1,
    input  logic [READ_PORTS*ADDR_W-1:0] read_addr,
    output logic [READ_PORTS*WIDTH-1:0]  read_data,
    output logic                         write_conflict
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [IDX_W-1:0] idx_t;

    // True when the address names a stored word.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Storage index of an address; only meaningful after addr_ok().
    function automatic idx_t idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    word_t                        bank0_mem [READ_PORTS][DEPTH];
    word_t                        bank1_mem [READ_PORTS][DEPTH];

    logic [DEPTH-1:0]             lvt_q, lvt_d;
    logic                         write_conflict_q, write_conflict_d;
    logic [READ_PORTS*WIDTH-1:0]  read_data_q, read_data_d;

    logic                         wr0_req, wr1_req;
    logic                         wr0_en, wr1_en;
    logic                         conflict;

    // Qualify writes. Writes are ignored while reset is asserted or when the
    // address is out of range. On a same-address collision, port 0 is
    // dropped. Only in-range collisions count as conflicts.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr0_req  = 1'b0;
        wr1_req  = 1'b0;
        conflict = 1'b0;
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_req  = reset_n && we_0 && addr_ok(write_addr_0);
        wr1_req  = reset_n && we_1 && addr_ok(write_addr_1);
        conflict = wr0_req && wr1_req && (write_addr_0 == write_addr_1);
        wr1_en   = wr1_req;
        wr0_en   = wr0_req && !conflict;
    end

    // Next LVT contents and the sticky conflict flag.
    always_comb begin
        lvt_d            = lvt_q;
        write_conflict_d = write_conflict_q | conflict;
        if (wr0_en) lvt_d[idx(write_addr_0)] = 1'b0;
        if (wr1_en) lvt_d[idx(write_addr_1)] = 1'b1;
    end

    // Per-port read mux. The LVT value from before this edge picks the bank.
    // Write-first forwarding is added only in the bypass build.
    always_comb begin : read_mux
        logic [ADDR_W-1:0] ra;
        word_t             word;
        read_data_d = '0;
        ra          = '0;
        word        = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            ra   = read_addr[k*ADDR_W +: ADDR_W];
            word = '0;
            if (addr_ok(ra)) begin
                word = lvt_q[idx(ra)] ? bank1_mem[k][idx(ra)] : bank0_mem[k][idx(ra)];
`ifdef MEM_LVT_BYPASS_EN
                if (wr1_en && (write_addr_1 == ra)) begin
                    word = write_data_1;
                end else if (wr0_en && (write_addr_0 == ra)) begin
                    word = write_data_0;
                end
`endif
            end
            read_data_d[k*WIDTH +: WIDTH] = word;
        end
    end

    // Bank replicas. Every read port has its own copy of both banks.
    // NOTE: the banks are deliberately left without a reset; contents stay undefined until written, which lets them map onto RAM.
    always_ff @(posedge clock) begin
        for (int k = 0; k < READ_PORTS; k++) begin
            if (wr0_en) bank0_mem[k][idx(write_addr_0)] <= write_data_0;
            if (wr1_en) bank1_mem[k][idx(write_addr_1)] <= write_data_1;
        end
    end

    // Control state and registered read data, cleared by asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            lvt_q            <= '0;
            write_conflict_q <= 1'b0;
            read_data_q      <= '0;
        end else begin
            lvt_q            <= lvt_d;
            write_conflict_q <= write_conflict_d;
            read_data_q      <= read_data_d;
        end
    end

    assign read_data      = read_data_q;
    assign write_conflict = write_conflict_q;

endmodule

// File: doc/mem_lvt_2wnr.md
MEM_LVT_2WNR -- requirements
Module: mem_lvt_2wnr

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of words.
REQ-003 SHALL have parameter ADDR_W, default 4, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter READ_PORTS, default 4, number of independent read ports (1..8).
REQ-005 SHALL have ports: one clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 we_0  input  1  write enable, write port 0.
REQ-009 write_addr_0  input  ADDR_W  write address, port 0.
REQ-010 write_data_0  input  WIDTH  write data, port 0.
REQ-011 we_1  input  1  write enable, write port 1.
REQ-012 write_addr_1  input  ADDR_W  write address, port 1.
REQ-013 write_data_1  input  WIDTH  write data, port 1.
REQ-014 read_addr  input  READ_PORTS*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-015 read_data  output  READ_PORTS*WIDTH  packed registered read data; port k at [k*WIDTH +: WIDTH].
REQ-016 write_conflict  output  1  sticky flag: both ports wrote the same address in one cycle.

Function
REQ-017 SHALL store data in two banks (bank 0 written only by port 0, bank 1 only by port 1), each replicated READ_PORTS times, one replica per read port.
REQ-018 SHALL keep a live value table (LVT) of DEPTH 1-bit entries; on a write by port p to address a, LVT[a] <= p at the same edge.
REQ-019 Read port k SHALL sample read_addr at edge N and present, after edge N+1... precisely: read_data[k] registered at edge N, valid from edge N until edge N+1 (1-cycle latency).
REQ-020 Read data SHALL be taken from the bank selected by LVT[read_addr_k] as it stood before edge N, unless REQ-027 applies.
REQ-021 Same-address simultaneous write (we_0 & we_1 & addresses equal): port 1 SHALL win; bank 1 written, LVT entry set to 1, bank 0 write suppressed.
REQ-022 On a REQ-021 event write_conflict SHALL be set at that edge and remain 1 until reset.
REQ-023 Writes to different addresses in the same cycle SHALL both complete with no interaction.
REQ-024 Addresses >= DEPTH SHALL be ignored for writes (no bank/LVT change) and SHALL return 0 for reads.
REQ-025 All READ_PORTS SHALL be fully independent; any ports may read the same address in the same cycle.

Reset
REQ-026 While reset_n = 0: all LVT entries = 0, read_data = 0, write_conflict = 0, writes ignored; bank contents are not reset (undefined until written); first valid read_data one edge after reset_n deasserts.

Configuration
REQ-027 Macro MEM_LVT_BYPASS_EN defined: a read of an address written in the same cycle SHALL return the new write data (write-first; port 1 data if both write it); undefined: SHALL return the pre-write contents (read-first).

Verification
REQ-028 Reset then write port 0 addr 3 = 0xDEADBEEF; next cycle read addr 3 on all 4 ports -> all read_data = 0xDEADBEEF one edge later.
REQ-029 Port 0 writes addr 5 = 0x11111111, next cycle port 1 writes addr 5 = 0x22222222; read addr 5 -> 0x22222222 (LVT selects bank 1); port 0 then writes 0x33333333 -> reads 0x33333333.
REQ-030 Same cycle: port 0 addr 7 = 0xAAAA0000, port 1 addr 7 = 0x0000BBBB -> read addr 7 = 0x0000BBBB, write_conflict = 1 and stays 1 over 10 further idle cycles; reset_n pulse -> write_conflict = 0.
REQ-031 Addr 2 holds 0x5; same cycle write addr 2 = 0x9 and read addr 2 -> 0x9 with MEM_LVT_BYPASS_EN, 0x5 without; following read 0x9 in both builds.
REQ-032 Assert reset_n low mid-stream with we_0 = 1 addr 1 = 0x77 -> read_data = 0 immediately (asynchronously), write not performed, LVT[all] = 0 after release.
REQ-033 Parameter sweep READ_PORTS = 1, 4, 8 and WIDTH = 8, 32: random 2-port writes / all-port reads for 10000 cycles against reference model -> zero mismatches.
